// File: rtl/fractal_solver_sequencer_pkg.sv
// Shared definitions for the fractal solver sequencer: state encoding,
// fractal mode codes and the accumulator control codes driven to the datapath.
package fractal_solver_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_ABS_FLUSH,
        ST_ITER,
        ST_ITER_FLUSH,
        ST_CHECK,
        ST_RESULT
    } state_t;

    localparam logic [1:0] MODE_MANDEL  = 2'd0;
    localparam logic [1:0] MODE_BSHIP   = 2'd1;
    localparam logic [1:0] MODE_TRICORN = 2'd2;

    localparam logic [1:0] ACC_ADD   = 2'd0;
    localparam logic [1:0] ACC_CARRY = 2'd1;
    localparam logic [1:0] ACC_SET   = 2'd2;
    localparam logic [1:0] ACC_NOP   = 2'd3;

    localparam logic [1:0] ABS_ACC_NONE  = 2'd0;
    localparam logic [1:0] ABS_ACC_START = 2'd1;
    localparam logic [1:0] ABS_ACC_CARRY = 2'd2;

    localparam int FLUSH_WAIT_DEF = 4;

    // The reserved mode code behaves exactly like Mandelbrot.
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_MANDEL : m;
    endfunction

endpackage

// File: rtl/fractal_sweep_counter.sv
// Limb sweep walker: L counts down; in pair mode each L walks p = 0..L/2 with
// flip 0/1 per p, in single mode each step is one limb. pattern restarts per L.
module fractal_sweep_counter #(
    parameter int LIMB_INDEX_BITS = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic [LIMB_INDEX_BITS-1:0] load_l,
    input  logic                       step,
    input  logic                       single,
    output logic [LIMB_INDEX_BITS-1:0] l,
    output logic [LIMB_INDEX_BITS-1:0] p,
    output logic                       flip,
    output logic [1:0]                 pattern,
    output logic                       last_of_l,
    output logic                       done
);
    localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE = LIMB_INDEX_BITS'(1);

    logic [LIMB_INDEX_BITS-1:0] l_q, l_d, p_q, p_d;
    logic                       flip_q, flip_d;
    logic [1:0]                 pattern_q, pattern_d;

    assign last_of_l = single | (flip_q & (p_q == (l_q >> 1)));
    assign done      = last_of_l & (l_q == '0);
    assign l         = l_q;
    assign p         = p_q;
    assign flip      = flip_q;
    assign pattern   = pattern_q;

    always_comb begin
        l_d       = l_q;
        p_d       = p_q;
        flip_d    = flip_q;
        pattern_d = pattern_q;
        if (load) begin
            l_d       = load_l;
            p_d       = '0;
            flip_d    = 1'b0;
            pattern_d = 2'd0;
        end else if (step) begin
            if (last_of_l) begin
                l_d       = l_q - LIMB_ONE;
                p_d       = '0;
                flip_d    = 1'b0;
                pattern_d = 2'd0;
            end else begin
                pattern_d = pattern_q + 2'd1;
                flip_d    = ~flip_q;
                if (flip_q) begin
                    p_d = p_q + LIMB_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            l_q       <= '0;
            p_q       <= '0;
            flip_q    <= 1'b0;
            pattern_q <= 2'd0;
        end else begin
            l_q       <= l_d;
            p_q       <= p_d;
            flip_q    <= flip_d;
            pattern_q <= pattern_d;
        end
    end

endmodule

// File: rtl/fractal_solver_sequencer.sv
// Sequences the multi-limb escape-time datapath: optional abs pass, partial
// product sweep, pipeline flushes, divergence check and a held result handshake.
module fractal_solver_sequencer
    import fractal_solver_sequencer_pkg::*;
#(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int ITER_BITS       = 16,
    parameter int FLUSH_WAIT      = FLUSH_WAIT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfg_wr_en,
    input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
    input  logic [ITER_BITS-1:0]       cfg_iter_lim,
    input  logic [1:0]                 cfg_mode,
    input  logic                       c_wr_re,
    input  logic                       c_wr_im,
    input  logic [LIMB_INDEX_BITS-1:0] c_wr_ind,
    input  logic                       start,
    input  logic                       abort,
    output logic [LIMB_INDEX_BITS-1:0] limb_ind,
    output logic [LIMB_INDEX_BITS-1:0] zre_ind,
    output logic [LIMB_INDEX_BITS-1:0] zim_ind,
    output logic                       cre_wr_en,
    output logic                       cim_wr_en,
    output logic                       op_abs,
    output logic                       flip,
    output logic [1:0]                 pattern,
    output logic [1:0]                 zre_acc_sel,
    output logic [1:0]                 zim_acc_sel,
    output logic                       zim_neg,
    output logic                       zre_wr_en,
    output logic                       zim_wr_en,
    input  logic                       zre_sign,
    input  logic                       zim_sign,
    input  logic                       diverged,
    output logic                       busy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ITER_BITS-1:0]       res_count,
    output logic                       res_diverged
);
    localparam int FW_BITS = (FLUSH_WAIT < 1) ? 1 : $clog2(FLUSH_WAIT + 1);
    localparam logic [FW_BITS-1:0]         FW_LAST  = FW_BITS'(FLUSH_WAIT);
    localparam logic [FW_BITS-1:0]         FW_ONE   = FW_BITS'(1);
    localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE = LIMB_INDEX_BITS'(1);
    localparam logic [ITER_BITS-1:0]       ITER_ONE = ITER_BITS'(1);

    state_t                     state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_d;
    logic [ITER_BITS-1:0]       iter_lim_q, iter_lim_d;
    logic [1:0]                 mode_q, mode_d;
    logic [ITER_BITS-1:0]       count_q, count_d;
    logic                       last_zre_sign_q, last_zre_sign_d;
    logic                       last_zim_sign_q, last_zim_sign_d;
    logic [FW_BITS-1:0]         flush_q, flush_d;
    logic [ITER_BITS-1:0]       res_count_q, res_count_d;
    logic                       res_diverged_q, res_diverged_d;

    logic                       sw_load, sw_step, sw_single, sw_flip, sw_last, sw_done;
    logic [LIMB_INDEX_BITS-1:0] sw_load_l, sw_l, sw_p, sw_lo, abs_top_l, first_load_l;
    logic [1:0]                 sw_pattern, mode_e;
    state_t                     first_sweep;

    fractal_sweep_counter #(.LIMB_INDEX_BITS(LIMB_INDEX_BITS)) u_sweep (
        .clock     (clock),
        .reset     (reset),
        .load      (sw_load),
        .load_l    (sw_load_l),
        .step      (sw_step),
        .single    (sw_single),
        .l         (sw_l),
        .p         (sw_p),
        .flip      (sw_flip),
        .pattern   (sw_pattern),
        .last_of_l (sw_last),
        .done      (sw_done)
    );

    // Burning Ship needs the abs pass in front of every sweep; the abs pass
    // walks N-1..0 while the partial sweep starts one limb higher at N.
    assign mode_e       = eff_mode(mode_q);
    assign first_sweep  = (mode_e == MODE_BSHIP) ? ST_ABS : ST_ITER;
    assign abs_top_l    = num_limbs_q - LIMB_ONE;
    assign first_load_l = (mode_e == MODE_BSHIP) ? abs_top_l : num_limbs_q;
    assign sw_single    = (state_q == ST_ABS);
    assign sw_lo        = sw_l - sw_p;

    assign busy         = (state_q != ST_IDLE);
    assign res_count    = res_count_q;
    assign res_diverged = res_diverged_q;

    always_comb begin
        state_d         = state_q;
        num_limbs_d     = num_limbs_q;
        iter_lim_d      = iter_lim_q;
        mode_d          = mode_q;
        count_d         = count_q;
        last_zre_sign_d = last_zre_sign_q;
        last_zim_sign_d = last_zim_sign_q;
        flush_d         = '0;
        res_count_d     = res_count_q;
        res_diverged_d  = res_diverged_q;
        sw_load         = 1'b0;
        sw_load_l       = first_load_l;
        sw_step         = 1'b0;
        limb_ind        = '0;
        zre_ind         = '0;
        zim_ind         = '0;
        cre_wr_en       = 1'b0;
        cim_wr_en       = 1'b0;
        op_abs          = 1'b0;
        flip            = 1'b0;
        pattern         = 2'd0;
        zre_acc_sel     = 2'd0;
        zim_acc_sel     = 2'd0;
        zim_neg         = 1'b0;
        zre_wr_en       = 1'b0;
        zim_wr_en       = 1'b0;
        res_valid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                limb_ind  = c_wr_ind;
                cre_wr_en = c_wr_re;
                cim_wr_en = c_wr_im;
                if (cfg_wr_en) begin
                    num_limbs_d = cfg_num_limbs;
                    iter_lim_d  = cfg_iter_lim;
                    mode_d      = cfg_mode;
                end else if (start) begin
                    count_d = '0;
                    state_d = first_sweep;
                    sw_load = 1'b1;
                end
            end
            ST_ABS: begin
                limb_ind    = sw_l;
                op_abs      = 1'b1;
                zre_ind     = sw_l;
                zim_ind     = sw_l;
                zre_wr_en   = 1'b1;
                zim_wr_en   = 1'b1;
                zre_acc_sel = !last_zre_sign_q ? ABS_ACC_NONE :
                              (sw_l == abs_top_l) ? ABS_ACC_START : ABS_ACC_CARRY;
                zim_acc_sel = !last_zim_sign_q ? ABS_ACC_NONE :
                              (sw_l == abs_top_l) ? ABS_ACC_START : ABS_ACC_CARRY;
                if (sw_done) state_d = ST_ABS_FLUSH;
                else         sw_step = 1'b1;
            end
            ST_ABS_FLUSH: begin
                if (flush_q == FW_LAST) begin
                    state_d   = ST_ITER;
                    sw_load   = 1'b1;
                    sw_load_l = num_limbs_q;
                end else begin
                    flush_d = flush_q + FW_ONE;
                end
            end
            ST_ITER: begin
                limb_ind = sw_l;
                flip     = sw_flip;
                pattern  = sw_pattern;
                zre_ind  = sw_flip ? sw_p : sw_lo;
                zim_ind  = sw_flip ? sw_lo : sw_p;
                zim_neg  = (mode_e == MODE_BSHIP)   ? (last_zre_sign_q ^ last_zim_sign_q) :
                           (mode_e == MODE_TRICORN);
                if (sw_p != '0) begin
                    zre_acc_sel = ACC_ADD;
                    zim_acc_sel = ACC_ADD;
                end else if (!sw_flip) begin
                    zre_acc_sel = ACC_NOP;
                    zim_acc_sel = (sw_l == num_limbs_q) ? ACC_SET : ACC_CARRY;
                end else begin
                    zre_acc_sel = (sw_l == num_limbs_q) ? ACC_SET : ACC_CARRY;
                    zim_acc_sel = ACC_ADD;
                end
                // The square term re*im on the diagonal is counted once, not twice.
                if (sw_flip && (sw_p == sw_lo)) zim_acc_sel = ACC_NOP;
                zre_wr_en = sw_last && (sw_l < num_limbs_q);
                zim_wr_en = sw_last && (sw_l < num_limbs_q);
                if (sw_done) state_d = ST_ITER_FLUSH;
                else         sw_step = 1'b1;
            end
            ST_ITER_FLUSH: begin
                if (flush_q == FW_LAST) state_d = ST_CHECK;
                else                    flush_d = flush_q + FW_ONE;
            end
            ST_CHECK: begin
                last_zre_sign_d = zre_sign;
                last_zim_sign_d = zim_sign;
                if (diverged) begin
                    res_count_d    = count_q;
                    res_diverged_d = 1'b1;
                    state_d        = ST_RESULT;
                end else if (count_q == iter_lim_q) begin
                    res_count_d    = iter_lim_q;
                    res_diverged_d = 1'b0;
                    state_d        = ST_RESULT;
                end else begin
                    count_d = count_q + ITER_ONE;
                    state_d = first_sweep;
                    sw_load = 1'b1;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE) && (state_q != ST_RESULT)) begin
            state_d   = ST_IDLE;
            sw_load   = 1'b0;
            sw_step   = 1'b0;
            zre_wr_en = 1'b0;
            zim_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            num_limbs_q     <= '0;
            iter_lim_q      <= '0;
            mode_q          <= 2'd0;
            count_q         <= '0;
            last_zre_sign_q <= 1'b0;
            last_zim_sign_q <= 1'b0;
            flush_q         <= '0;
            res_count_q     <= '0;
            res_diverged_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_limbs_q     <= num_limbs_d;
            iter_lim_q      <= iter_lim_d;
            mode_q          <= mode_d;
            count_q         <= count_d;
            last_zre_sign_q <= last_zre_sign_d;
            last_zim_sign_q <= last_zim_sign_d;
            flush_q         <= flush_d;
            res_count_q     <= res_count_d;
            res_diverged_q  <= res_diverged_d;
        end
    end

endmodule

// File: doc/fractal_solver_sequencer.md
FRACTAL_SOLVER_SEQUENCER -- requirements
Module: fractal_solver_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  LIMB_INDEX_BITS, 6, width of limb indices.
  ITER_BITS, 16, width of iteration counter and limit.
  FLUSH_WAIT, 4, datapath pipeline depth in cycles (at least 1).
REQ-002 Ports, one per line: name, direction, width, meaning.
  clock in 1 clock; reset in 1 reset, synchronous, active-high.
  cfg_wr_en in 1 latch cfg_num_limbs, cfg_iter_lim and cfg_mode (IDLE only).
  cfg_num_limbs in LIMB_INDEX_BITS limb count N (at least 1).
  cfg_iter_lim in ITER_BITS iteration limit.
  cfg_mode in 2 mode: 0 Mandelbrot, 1 Burning Ship, 2 Tricorn, 3 reserved (treated as 0).
  c_wr_re, c_wr_im in 1 each, c limb write strobes (IDLE only); c_wr_ind in LIMB_INDEX_BITS limb address.
  start in 1 begin solve; abort in 1 cancel solve.
  limb_ind, zre_ind, zim_ind out LIMB_INDEX_BITS each, limb addresses.
  cre_wr_en, cim_wr_en out 1 each.
  op_abs out 1: datapath in abs mode.
  flip out 1: cross-term half of a partial pair.
  pattern out 2: operand-select pattern index.
  zre_acc_sel, zim_acc_sel out 2 each: accumulator control codes.
  zim_neg out 1: negate zim partial.
  zre_wr_en, zim_wr_en out 1 each: z limb writeback.
  zre_sign, zim_sign, diverged in 1 each, datapath status.
  busy out 1.
  res_valid out 1; res_ready in 1; res_count out ITER_BITS; res_diverged out 1.

Function
REQ-003 States: IDLE, ABS, ABS_FLUSH, ITER, ITER_FLUSH, CHECK, RESULT.
REQ-004 IDLE: limb_ind = c_wr_ind; cre_wr_en = c_wr_re; cim_wr_en = c_wr_im; cfg latched on cfg_wr_en.
REQ-005 start in IDLE: go to ABS when the latched mode is 1, else to ITER; clear iteration count; busy = 1 from the next cycle.
REQ-006 ABS: one cycle per limb, L = N-1 down to 0.
  op_abs = 1; zre_ind = zim_ind = L; both wr_en = 1.
  acc_sel for a component is 1 (start) at L = N-1 or 2 (carry) otherwise, when its latched sign is 1; 0 when its sign is 0.
REQ-007 ABS exit: after L = 0, go to ABS_FLUSH.
REQ-008 Each flush state lasts exactly FLUSH_WAIT+1 cycles, with all write enables 0. ABS_FLUSH goes to ITER; ITER_FLUSH goes to CHECK.
REQ-009 ITER sweep: L from N down to 0. For each L, p runs 0..floor(L/2); each p spans two cycles, flip = 0 then 1. pattern increments per cycle and resets to 0 at each new L.
REQ-010 ITER indices: flip=0 gives zre_ind = L-p, zim_ind = p; flip=1 swaps them.
REQ-011 ITER writeback: zre_wr_en = zim_wr_en = 1 on the last cycle of each L where L < N. After L = 0, go to ITER_FLUSH.
REQ-012 zim_neg = last_zre_sign XOR last_zim_sign in mode 1; 1 in mode 2; 0 otherwise.
REQ-013 Accumulator codes during ITER: 0 add, 1 carry, 2 set, 3 nop.
  p = 0, flip = 0: zre gets nop; zim gets set at L = N, else carry.
  p = 0, flip = 1: zre gets set at L = N, else carry; zim gets add.
  p > 0: both get add.
  zim gets nop whenever zre_ind == zim_ind and flip = 1.
REQ-014 CHECK (one cycle): latch zre_sign and zim_sign.
  diverged = 1: go to RESULT with the current count and res_diverged = 1.
  Otherwise, count == limit: go to RESULT with count = limit and res_diverged = 0.
  Otherwise: increment count and go to ABS or ITER per mode.
  diverged takes priority when both conditions hold.
REQ-015 RESULT: res_valid = 1 with res_count and res_diverged stable. The handshake occurs when res_ready = 1, after which the block returns to IDLE; busy is 0 only in IDLE.
REQ-016 abort = 1 in any non-IDLE state except RESULT: next state IDLE, no result produced, write enables forced 0 that cycle. In RESULT, abort is ignored.
REQ-017 In IDLE: start is ignored while cfg_wr_en = 1; abort has no effect.
REQ-018 All index arithmetic wraps modulo 2^LIMB_INDEX_BITS; N = 2^LIMB_INDEX_BITS-1 is legal. The counter never wraps because the limit is checked first.

Reset
REQ-019 Reset state and register values:
  state IDLE; res_valid 0; busy 0; res_count 0; res_diverged 0.
  num_limbs 0; iter limit 0; mode 0; last signs 0.
  limb, partial, flip, pattern and flush counters all 0.
REQ-020 Reset mid-solve discards all progress. All combinational outputs take their IDLE values one cycle after reset is asserted.

Structure
REQ-021 A shared package holds: state encoding, mode codes, ITER/ABS accumulator codes, and FLUSH_WAIT default.
REQ-022 The sweep counter (L, p, flip, pattern, with a last-of-L flag) is one sub-module: fractal_sweep_counter.

Verification
REQ-023 Directed scenarios, stimulus -> required response:
  N=1, mode 0: ITER gives 4 cycles (L=1 p=0, L=0 p=0), one writeback pulse, flush of FLUSH_WAIT+1 cycles, then CHECK.
  N=3, mode 1, signs latched 1/0: ABS gives zre_acc_sel 1,2,2 and zim_acc_sel 0,0,0.
  limit=5, diverged held 0: res_count=5, res_diverged=0; res_ready held 0 for 10 cycles keeps res_valid=1 with stable data.
  diverged=1 at the third CHECK: res_count=2, res_diverged=1.
  abort mid-ITER: IDLE next cycle, no res_valid, a following start runs normally.
  mode 2: zim_neg=1 throughout ITER; no ABS state is visited.
